apb_pwm_slave: RTL and testbench
================================

Name: apb_pwm_slave

Overview:
- APB3 completer for the fabric side of the MSS APB master interface.
- Holds a 4-channel PWM register bank that drives the suit's LED/driver lines.
- Decodes the MSS APB strobes and inserts one wait state on reads.
- Flags bad accesses with PSLVERR.
- Double-buffers PERIOD/DUTY so updates land glitch-free on period boundaries.

Parameters:
NUM_CH, 4, number of PWM channels (1..4)
CNT_W, 16, PWM counter/period/duty width (≤16)

Ports:
PCLK  in  1  fabric clock
PRESERN  in  1  reset, synchronous, active-low
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  1=write
PADDR  in  8  byte address
PWDATA  in  32  write data
PRDATA  out  32  read data
PREADY  out  1  transfer complete
PSLVERR  out  1  transfer error (valid with PREADY)
PWM_OUT  out  NUM_CH  PWM outputs
PWM_IRQ  out  1  period-wrap interrupt, level

Behaviour:
- Reset: one clock; synchronous, active-low, PRESERN sampled on PCLK rising edge. PRESERN=0 forces:
  - PRDATA=0, PREADY=0, PSLVERR=0, PWM_OUT=0, PWM_IRQ=0.
  - CTRL=0, PRESCALE=0, counter=0, prescaler=0, IRQ flag=0.
  - PERIOD shadow/active=all-ones; DUTY shadow/active=0.
  - Any in-flight read is abandoned.
- Register map (word-aligned):
  - 0x00 CTRL RW: bit0 EN, bit1 IRQ_EN, bits[NUM_CH+3:4] channel enable.
  - 0x04 PERIOD RW (shadow).
  - 0x08 PRESCALE RW [7:0].
  - 0x0C STATUS: bit0 running (RO), bit1 IRQ flag (W1C), bits[CNT_W+15:16] counter (RO).
  - 0x10+4*i DUTY_i RW (shadow), i<NUM_CH.
  - Unused bits read 0. Reads of PERIOD/DUTY return shadow values.
- APB error:
  - PSLVERR=1 when PADDR[1:0]≠0 or PADDR > 0x10+4*(NUM_CH-1).
  - Errored writes change no state; errored reads return PRDATA=0.
- APB write timing: zero wait states. PREADY=1 combinationally whenever PSEL&PENABLE&PWRITE. Register updates on that edge.
- APB read timing: exactly one wait state.
  - Setup cycle (PSEL&!PENABLE&!PWRITE): read data is registered.
  - First access cycle: PREADY=0.
  - Second access cycle: PREADY=1, PRDATA and PSLVERR valid.
  - An internal rd_done flag clears when PSEL drops.
  - PRDATA holds its last value outside reads.
- PREADY=0 whenever PSEL=0.
- Prescaler: counts 0..PRESCALE. A tick fires when it equals PRESCALE, then it reloads 0. PRESCALE=0 gives a tick every cycle.
- Counter: advances on each tick while EN=1.
  - Counts 0..PERIOD_active, then wraps to 0.
  - PERIOD_active=0 holds the counter at 0 with a wrap on every tick.
- Shadow load: shadow→active copy of PERIOD and all DUTY_i happens:
  - on the wrap tick, or
  - every cycle while EN=0.
- EN 1→0: counter and prescaler clear to 0 the next cycle.
- PWM_OUT[i] registered = EN & ch_en[i] & (counter < DUTY_active[i]).
  - DUTY=0 gives constant 0.
  - DUTY>PERIOD gives constant 1.
  - One cycle latency from the counter.
- IRQ flag:
  - Sets on a wrap tick.
  - W1C write to STATUS bit1 clears it.
  - Set has priority when set and clear land in the same cycle.
  - PWM_IRQ = flag & IRQ_EN.
- STATUS bit0 = EN.
- Reset mid-read: PREADY=0 next cycle; the master's transfer is abandoned.

Test Plan:
- Reset & readback: assert PRESERN=0 3 cycles, then read 0x04 → PRDATA=0x0000FFFF, PREADY low 1 access cycle then high, PSLVERR=0. Read 0x00 → 0.
- Write/read all registers: PRESCALE=0x12, DUTY_2=0x0055 → each reads back exactly. Write to 0x22 → PSLVERR=1, no state change. Read 0x40 → PSLVERR=1, PRDATA=0.
- Basic PWM: PERIOD=9, PRESCALE=0, DUTY_0=3, CTRL=0x13 → PWM_OUT[0] high 3 cycles, low 7 cycles, repeating period 10. PWM_OUT[1..3]=0.
- Glitch-free update: mid-period write DUTY_0=7 → current period keeps 3-high. Next period (after wrap) shows 7-high.
- Boundaries and prescaler: DUTY_0=0 → constant 0. DUTY_0=10 → constant 1. PRESCALE=3 → period stretches to 40 cycles.
- IRQ: IRQ_EN=1, wrap → PWM_IRQ=1. Write STATUS=0x2 → clears. Clear coincident with wrap → stays 1. EN→0 → counter reads 0 in STATUS.

Source files
------------

// File: rtl/apb_pwm_slave.sv
// APB3 completer holding a double-buffered multi-channel PWM register bank.
// Writes complete with zero wait states; reads insert exactly one wait state.
module apb_pwm_slave #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              PCLK,
  input  logic              PRESERN,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [7:0]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [NUM_CH-1:0] PWM_OUT,
  output logic              PWM_IRQ
);

  localparam logic [7:0] MaxAddr = 8'(16 + 4 * (NUM_CH - 1));

  logic              en_q, en_d, irq_en_q, irq_en_d;
  logic [NUM_CH-1:0] ch_en_q, ch_en_d;
  logic [CNT_W-1:0]  period_sh_q, period_sh_d, period_act_q, period_act_d;
  logic [CNT_W-1:0]  duty_sh_q [NUM_CH];
  logic [CNT_W-1:0]  duty_sh_d [NUM_CH];
  logic [CNT_W-1:0]  duty_act_q [NUM_CH];
  logic [CNT_W-1:0]  duty_act_d [NUM_CH];
  logic [7:0]        prescale_q, prescale_d, psc_q, psc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              irq_q, irq_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic [31:0]       prdata_q, prdata_d;
  logic              rerr_q, rerr_d, rd_arm_q, rd_arm_d, rd_done_q, rd_done_d;

  logic        addr_err, wr_ok, rd_setup, w1c, tick, wrap, load;
  logic [31:0] rdata;
  logic        unused_pwdata;

  assign unused_pwdata = ^PWDATA;

  assign addr_err = (PADDR[1:0] != 2'b00) || (PADDR > MaxAddr);
  assign wr_ok    = PSEL & PENABLE & PWRITE & ~addr_err;
  assign rd_setup = PSEL & ~PENABLE & ~PWRITE;

  assign tick = en_q && (psc_q == prescale_q);
  assign wrap = tick && (cnt_q == period_act_q);
  // Shadows track freely while stopped so the first enabled period uses fresh values.
  assign load = wrap || !en_q;

  always_comb begin
    rdata = '0;
    if (!addr_err) begin
      case (PADDR[7:2])
        6'd0: begin
          rdata[0]            = en_q;
          rdata[1]            = irq_en_q;
          rdata[NUM_CH+3:4]   = ch_en_q;
        end
        6'd1: rdata[CNT_W-1:0] = period_sh_q;
        6'd2: rdata[7:0]       = prescale_q;
        6'd3: begin
          rdata[0]            = en_q;
          rdata[1]            = irq_q;
          rdata[CNT_W+15:16]  = cnt_q;
        end
        default: begin
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (PADDR[7:2] == 6'(4 + i)) rdata[CNT_W-1:0] = duty_sh_q[i];
          end
        end
      endcase
    end
  end

  always_comb begin
    en_d        = en_q;
    irq_en_d    = irq_en_q;
    ch_en_d     = ch_en_q;
    period_sh_d = period_sh_q;
    prescale_d  = prescale_q;
    duty_sh_d   = duty_sh_q;
    w1c         = 1'b0;
    if (wr_ok) begin
      case (PADDR[7:2])
        6'd0: begin
          en_d     = PWDATA[0];
          irq_en_d = PWDATA[1];
          ch_en_d  = PWDATA[NUM_CH+3:4];
        end
        6'd1: period_sh_d = PWDATA[CNT_W-1:0];
        6'd2: prescale_d  = PWDATA[7:0];
        6'd3: w1c         = PWDATA[1];
        default: begin
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (PADDR[7:2] == 6'(4 + i)) duty_sh_d[i] = PWDATA[CNT_W-1:0];
          end
        end
      endcase
    end

    psc_d = (!en_q || tick) ? 8'd0 : psc_q + 8'd1;
    if (!en_q || wrap) cnt_d = '0;
    else if (tick)     cnt_d = cnt_q + 1'b1;
    else               cnt_d = cnt_q;

    period_act_d = load ? period_sh_q : period_act_q;
    duty_act_d   = load ? duty_sh_q : duty_act_q;

    // A wrap in the same cycle as a W1C keeps the flag set.
    irq_d = wrap ? 1'b1 : (w1c ? 1'b0 : irq_q);

    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = en_q & ch_en_q[i] & (cnt_q < duty_act_q[i]);
    end

    prdata_d = prdata_q;
    rerr_d   = rerr_q;
    rd_arm_d = rd_arm_q;
    if (rd_setup) begin
      prdata_d = rdata;
      rerr_d   = addr_err;
      rd_arm_d = 1'b1;
    end else if (!PSEL || PENABLE) begin
      rd_arm_d = 1'b0;
    end
    rd_done_d = PSEL & PENABLE & ~PWRITE & rd_arm_q;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      en_q         <= 1'b0;
      irq_en_q     <= 1'b0;
      ch_en_q      <= '0;
      period_sh_q  <= '1;
      period_act_q <= '1;
      prescale_q   <= '0;
      psc_q        <= '0;
      cnt_q        <= '0;
      irq_q        <= 1'b0;
      pwm_q        <= '0;
      prdata_q     <= '0;
      rerr_q       <= 1'b0;
      rd_arm_q     <= 1'b0;
      rd_done_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        duty_sh_q[i]  <= '0;
        duty_act_q[i] <= '0;
      end
    end else begin
      en_q         <= en_d;
      irq_en_q     <= irq_en_d;
      ch_en_q      <= ch_en_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      prescale_q   <= prescale_d;
      psc_q        <= psc_d;
      cnt_q        <= cnt_d;
      irq_q        <= irq_d;
      pwm_q        <= pwm_d;
      prdata_q     <= prdata_d;
      rerr_q       <= rerr_d;
      rd_arm_q     <= rd_arm_d;
      rd_done_q    <= rd_done_d;
      duty_sh_q    <= duty_sh_d;
      duty_act_q   <= duty_act_d;
    end
  end

  assign PREADY  = PRESERN & PSEL & PENABLE & (PWRITE | rd_done_q);
  assign PSLVERR = PREADY & (PWRITE ? addr_err : rerr_q);
  assign PRDATA  = prdata_q;
  assign PWM_OUT = pwm_q;
  assign PWM_IRQ = irq_q & irq_en_q;

endmodule

// File: tb/tb_apb_pwm_slave.sv
// Directed bench for apb_pwm_slave: APB register access, PWM waveform run lengths and IRQ.
module tb_apb_pwm_slave;

  logic        PCLK = 1'b0;
  logic        PRESERN, PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR, PWM_IRQ;
  logic [3:0]  PWM_OUT;

  int vecs = 0;
  int errs = 0;
  logic [32:0] rd_exp_q [$];
  int          run_exp_q [$];

  apb_pwm_slave #(.NUM_CH(4), .CNT_W(16)) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .PWM_OUT(PWM_OUT), .PWM_IRQ(PWM_IRQ)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick1();
    @(posedge PCLK); #1;
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, input logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    tick1();
    PENABLE = 1'b1;
    #1;
    chk("wr_pready", {31'd0, PREADY}, 32'd1);
    chk("wr_pslverr", {31'd0, PSLVERR}, {31'd0, err});
    tick1();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, input logic [31:0] d, input logic err);
    logic [32:0] e;
    rd_exp_q.push_back({err, d});
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    tick1();
    PENABLE = 1'b1;
    #1;
    chk("rd_wait_state", {31'd0, PREADY}, 32'd0);
    tick1();
    chk("rd_pready", {31'd0, PREADY}, 32'd1);
    e = rd_exp_q.pop_front();
    chk("rd_prdata", PRDATA, e[31:0]);
    chk("rd_pslverr", {31'd0, PSLVERR}, {31'd0, e[32]});
    tick1();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_level(input logic lvl, input string tag);
    int n = 0;
    while (PWM_OUT[0] !== lvl && n < 300) begin
      tick1();
      n++;
    end
    if (n == 300) chk(tag, {31'd0, PWM_OUT[0]}, {31'd0, lvl});
  endtask

  task automatic run_len(input logic lvl, input int pre, output int n);
    n = pre;
    for (int k = 0; k < 300; k++) begin
      tick1();
      if (PWM_OUT[0] === lvl) n++;
      else break;
    end
  endtask

  task automatic check_run(input logic lvl, input int pre, input int exp, input string tag);
    int n;
    run_exp_q.push_back(exp);
    run_len(lvl, pre, n);
    chk(tag, n, run_exp_q.pop_front());
  endtask

  task automatic count_ones(input int settle, input int exp, input string tag);
    int ones = 0;
    repeat (settle) tick1();
    for (int k = 0; k < 20; k++) begin
      tick1();
      if (PWM_OUT[0] === 1'b1) ones++;
    end
    chk(tag, ones, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESERN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    repeat (3) tick1();
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_pready", {31'd0, PREADY}, 32'd0);
    chk("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
    chk("rst_pwm", {28'd0, PWM_OUT}, 32'd0);
    chk("rst_irq", {31'd0, PWM_IRQ}, 32'd0);
    PRESERN = 1'b1;
    apb_read(8'h04, 32'h0000_FFFF, 1'b0);
    apb_read(8'h00, 32'h0, 1'b0);
    apb_read(8'h0C, 32'h0, 1'b0);

    // Register readback, masking of unused bits, and error handling.
    apb_write(8'h08, 32'hFFFF_FF12, 1'b0);
    apb_read(8'h08, 32'h12, 1'b0);
    apb_write(8'h18, 32'h0000_0055, 1'b0);
    apb_read(8'h18, 32'h55, 1'b0);
    apb_write(8'h04, 32'h1234_5678, 1'b0);
    apb_read(8'h04, 32'h5678, 1'b0);
    apb_write(8'h00, 32'hFFFF_FFFE, 1'b0);
    apb_read(8'h00, 32'hF2, 1'b0);
    apb_write(8'h00, 32'h0, 1'b0);
    apb_write(8'h22, 32'hFFFF_FFFF, 1'b1);
    apb_write(8'h05, 32'h0000_AAAA, 1'b1);
    apb_write(8'h1A, 32'h0000_0001, 1'b1);
    apb_read(8'h08, 32'h12, 1'b0);
    apb_read(8'h18, 32'h55, 1'b0);
    apb_read(8'h04, 32'h5678, 1'b0);
    apb_read(8'h40, 32'h0, 1'b1);
    apb_read(8'h1C, 32'h0, 1'b0);
    apb_read(8'h20, 32'h0, 1'b1);

    // Basic PWM: period 10, 3 high.
    apb_write(8'h08, 32'd0, 1'b0);
    apb_write(8'h04, 32'd9, 1'b0);
    apb_write(8'h10, 32'd3, 1'b0);
    apb_write(8'h00, 32'h13, 1'b0);
    wait_level(1'b1, "basic_rise_timeout");
    check_run(1'b1, 1, 3, "basic_high");
    check_run(1'b0, 1, 7, "basic_low");
    chk("pwm_other_ch", {29'd0, PWM_OUT[3:1]}, 32'd0);

    // Mid-period duty change lands only after the wrap.
    check_run(1'b1, 1, 3, "glitch_cur_high");
    apb_write(8'h10, 32'd7, 1'b0);
    check_run(1'b0, 3, 7, "glitch_cur_low");
    check_run(1'b1, 1, 7, "glitch_next_high");
    check_run(1'b0, 1, 3, "glitch_next_low");

    apb_write(8'h10, 32'd0, 1'b0);
    count_ones(25, 0, "duty0_const_low");
    apb_write(8'h10, 32'd10, 1'b0);
    count_ones(25, 20, "duty_gt_period_const_high");

    apb_write(8'h10, 32'd3, 1'b0);
    apb_write(8'h08, 32'd3, 1'b0);
    wait_level(1'b0, "psc_fall_timeout");
    wait_level(1'b1, "psc_rise_timeout");
    check_run(1'b1, 1, 12, "psc_high");
    check_run(1'b0, 1, 28, "psc_low");

    // Now one sample after the edge following a wrap; next wrap is 40 edges after that wrap.
    chk("irq_set", {31'd0, PWM_IRQ}, 32'd1);
    apb_write(8'h0C, 32'h2, 1'b0);
    chk("irq_cleared", {31'd0, PWM_IRQ}, 32'd0);
    repeat (35) tick1();
    chk("irq_before_wrap", {31'd0, PWM_IRQ}, 32'd0);
    apb_write(8'h0C, 32'h2, 1'b0);
    chk("irq_set_beats_clear", {31'd0, PWM_IRQ}, 32'd1);

    apb_write(8'h00, 32'h12, 1'b0);
    tick1();
    chk("en_off_pwm", {28'd0, PWM_OUT}, 32'd0);
    apb_read(8'h0C, 32'h2, 1'b0);
    apb_write(8'h0C, 32'h2, 1'b0);
    apb_read(8'h0C, 32'h0, 1'b0);
    chk("irq_off", {31'd0, PWM_IRQ}, 32'd0);

    // Reset during a read abandons it.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h08;
    tick1();
    PENABLE = 1'b1;
    PRESERN = 1'b0;
    tick1();
    chk("rst_mid_read_pready", {31'd0, PREADY}, 32'd0);
    chk("rst_mid_read_prdata", PRDATA, 32'd0);
    PRESERN = 1'b1;
    tick1();
    chk("rst_mid_read_abandoned", {31'd0, PREADY}, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    tick1();
    apb_read(8'h04, 32'h0000_FFFF, 1'b0);
    apb_read(8'h08, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
